// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
//   Time-multiplexed driver for an eight-digit, common-anode seven-segment
//   display. Eight BCD digits are captured into a pending register. They move
//   into the display register only at a frame boundary, so a frame never
//   shows a mix of old and new digits.
//
// Parameters
//   CLK_FREQ    input clock frequency in Hz
//   REFRESH_HZ  per-digit scan step rate in Hz
//               (TICK_DIV = CLK_FREQ/REFRESH_HZ must be >= 2)
//
// Ports
//   clk          system clock, rising edge
//   reset_n      synchronous, active-low reset
//   digits_in    eight BCD nibbles, [3:0] = digit 0 (rightmost)
//   dp_in        decimal point per digit, 1 = lit
//   load         single-cycle strobe capturing digits_in/dp_in
//   pending      captured data is waiting for the next frame boundary
//   frame_start  one-cycle pulse on the tick where the scan wraps 7 -> 0
//   seg          active-low segments, seg[0] = a ... seg[6] = g
//   dp           active-low decimal point
//   an           active-low anodes, an[i] enables digit i
//
// Build option
//   SEG7_LZB_EN  when defined, enables leading-zero blanking. Zero digits
//                above the highest nonzero digit are blanked. Digit 0 is
//                never blanked.
//
// Handshake: load is a plain strobe with no ready. A load in any cycle is
// always accepted, and the last load before a frame boundary wins.
module seg7_scan_mux #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  input  logic        load,
  output logic        pending,
  output logic        frame_start,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an
);

  localparam int TICK_DIV = CLK_FREQ / REFRESH_HZ;
  localparam int CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          tick;
  logic [31:0]   pend_digits;
  logic [7:0]    pend_dp;
  logic [31:0]   disp_digits;
  logic [7:0]    disp_dp;
  logic [3:0]    cur_nib;
  logic          lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;  // non-BCD values are shown blank
    endcase
  endfunction

  assign tick        = (cnt == TICK_LAST);
  assign frame_start = tick && (idx == 3'd7);
  assign cur_nib     = disp_digits[{idx, 2'b00} +: 4];

`ifdef SEG7_LZB_EN
  // blank_mask[i] is set when digit i and every digit above it are zero.
  logic [7:0] blank_mask;
  always_comb begin
    logic zero_above;
    blank_mask = '0;
    zero_above = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      if (disp_digits[4*i +: 4] != 4'd0) zero_above = 1'b0;
      blank_mask[i] = zero_above;
    end
  end
  assign lz_blank = blank_mask[idx];
`else
  assign lz_blank = 1'b0;
`endif

  // Scan timing: tick divider and digit index.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Data path. A load on the frame boundary goes straight to the display
  // register, so older pending data never reaches the display.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      disp_digits <= '0;
      disp_dp     <= '0;
      pending     <= 1'b0;
    end else if (load && frame_start) begin
      disp_digits <= digits_in;
      disp_dp     <= dp_in;
      pending     <= 1'b0;
    end else if (load) begin
      pend_digits <= digits_in;
      pend_dp     <= dp_in;
      pending     <= 1'b1;
    end else if (frame_start && pending) begin
      disp_digits <= pend_digits;
      disp_dp     <= pend_dp;
      pending     <= 1'b0;
    end
  end

  // Registered display drive. These outputs lag idx by one clock.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'd1 << idx);
      seg <= lz_blank ? 7'h7F : decode(cur_nib);
      dp  <= ~disp_dp[idx];
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] digits_in;
  logic [7:0]  dp_in;
  logic        load;
  logic        pending;
  logic        frame_start;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;

  seg7_scan_mux #(.CLK_FREQ(16), .REFRESH_HZ(4)) dut (
    .clk(clk), .reset_n(reset_n), .digits_in(digits_in), .dp_in(dp_in),
    .load(load), .pending(pending), .frame_start(frame_start),
    .seg(seg), .dp(dp), .an(an)
  );

  // clock / reset block
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] digits;
    logic [7:0]  dpv;
    logic [6:0]  d0_seg;
  } vec_t;

  vec_t        tbl[6];
  logic [15:0] exp_q[$];  // {an, seg, dp}
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cur_d = '0;
  logic [7:0]  cur_p = '0;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [15:0] exp_word(input logic [31:0] d, input logic [7:0] p,
                                           input int i);
    logic [6:0] s;
    logic [7:0] a;
    int hi;
    hi = -1;
    for (int k = 7; k >= 0; k--) if (hi < 0 && d[4*k +: 4] != 4'd0) hi = k;
    s = ref_seg(d[4*i +: 4]);
`ifdef SEG7_LZB_EN
    if (i > 0 && i > hi) s = 7'h7F;
`endif
    a = 8'hFF;
    a[i] = 1'b0;
    return {a, s, ~p[i]};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Waits for the next frame_start, sampling on falling edges.
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 200);
    if (!frame_start) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_start_timeout: got no pulse expected one within 200 cycles");
    end
  endtask

  task automatic drive_load(input logic [31:0] d, input logic [7:0] p, input bit push);
    digits_in = d;
    dp_in     = p;
    load      = 1'b1;
    if (push) for (int i = 0; i < 8; i++) exp_q.push_back(exp_word(d, p, i));
    @(negedge clk);
    load = 1'b0;
  endtask

  // Starts at the frame_start cycle plus (3 - first_wait) cycles and checks
  // each digit in the middle of its scan slot.
  task automatic sample_frame(input int first_wait, input logic [6:0] d0);
    logic [15:0] e;
    for (int d = 0; d < 8; d++) begin
      repeat (d == 0 ? first_wait : 4) @(negedge clk);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_empty: got no entry expected one for digit %0d", d);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("digit%0d", d), {an, seg, dp}, e);
      end
      if (d == 0) check("digit0_seg", {9'd0, seg}, {9'd0, d0});
    end
  endtask

  task automatic load_mid(input logic [31:0] d, input logic [7:0] p, input logic [6:0] d0);
    int n;
    int k;
    wait_fs(n);
    k = $urandom_range(3, 20);
    repeat (k) @(negedge clk);
    drive_load(d, p, 1'b1);
    check("pending_set", {15'd0, pending}, 16'd1);
    check("display_held", {an, seg, dp}, exp_word(cur_d, cur_p, (k - 1) / 4));
    wait_fs(n);
    check("frame_period", n[15:0], 16'(31 - k));
    sample_frame(3, d0);
    cur_d = d;
    cur_p = p;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    load = 1'b0;
    digits_in = '0;
    dp_in = '0;
    tbl[0] = '{32'h87654321, 8'h01, 7'h79};
    tbl[1] = '{32'h0000A0C5, 8'h00, 7'h12};
    tbl[2] = '{32'h09876543, 8'hAA, 7'h30};
    tbl[3] = '{32'hFEDCBA98, 8'h80, 7'h00};
    tbl[4] = '{32'h00000000, 8'hFF, 7'h40};
    tbl[5] = '{{$urandom_range(0, 32'h0FFF_FFFF), 4'h7}, 8'($urandom_range(0, 255)), 7'h78};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_out", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
    check("reset_pending", {14'd0, pending, frame_start}, 16'd0);

    // Release: digit 0 of the zeroed display comes out immediately, then
    // the anodes step every 4 clocks.
    reset_n = 1'b1;
    @(negedge clk);
    check("release_first", {an, seg, dp}, {8'hFE, 7'h40, 1'b1});
    for (int c = 2; c <= 30; c++) begin
      @(negedge clk);
      if ((c - 2) % 4 == 0) check("idle_scan", {an, seg, dp}, exp_word('0, '0, (c - 2) / 4));
    end
    wait_fs(n);
    check("first_fs_pos", n[15:0], 16'd1);
    wait_fs(n);
    check("fs_period", n[15:0], 16'd32);

    // Table of patterns, each loaded mid-frame.
    for (int v = 0; v < 6; v++) load_mid(tbl[v].digits, tbl[v].dpv, tbl[v].d0_seg);

    // Two loads in one frame: only the last one is displayed.
    wait_fs(n);
    repeat (5) @(negedge clk);
    drive_load(32'h11111111, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    drive_load(32'h22222222, 8'h00, 1'b1);
    check("pending_dbl", {15'd0, pending}, 16'd1);
    wait_fs(n);
    check("fs_period_dbl", n[15:0], 16'd23);
    sample_frame(3, 7'h24);
    cur_d = 32'h22222222;
    cur_p = 8'h00;

    // Load on the frame_start cycle goes straight to the display.
    wait_fs(n);
    drive_load(32'h00000009, 8'h00, 1'b1);
    check("pending_bypass", {15'd0, pending}, 16'd0);
    sample_frame(2, 7'h10);
    cur_d = 32'h00000009;

    // Reset during digit 5 with pending data.
    wait_fs(n);
    repeat (3) @(negedge clk);
    drive_load(32'h33333333, 8'hFF, 1'b0);
    check("pending_pre_rst", {15'd0, pending}, 16'd1);
    repeat (18) @(negedge clk);
    check("digit5_slot", {8'd0, an}, 16'hDF);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_out", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
    check("midrst_pending", {14'd0, pending, frame_start}, 16'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_release", {an, seg, dp}, {8'hFE, 7'h40, 1'b1});
    repeat (3) @(negedge clk);
    check("midrst_d0_end", {8'd0, an}, 16'hFE);
    @(negedge clk);
    check("midrst_d1", {an, seg, dp}, {8'hFD, 7'h40, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected one before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter REFRESH_HZ, default 1000, per-digit scan step rate in Hz; TICK_DIV = CLK_FREQ/REFRESH_HZ (integer division) SHALL be >= 2.
REQ-003 Port clk  input  1  system clock, all logic on rising edge.
REQ-004 Port reset_n  input  1  synchronous, active-low reset.
REQ-005 Port digits_in  input  32  eight BCD nibbles, [3:0]=digit 0 (rightmost) ... [31:28]=digit 7.
REQ-006 Port dp_in  input  8  decimal point per digit, 1=lit, bit i = digit i.
REQ-007 Port load  input  1  single-cycle strobe capturing digits_in/dp_in.
REQ-008 Port pending  output  1  high while captured data awaits transfer to display register.
REQ-009 Port frame_start  output  1  one-cycle pulse when scan wraps from digit 7 to digit 0.
REQ-010 Port seg  output  7  active-low segments, seg[0]=a ... seg[6]=g.
REQ-011 Port dp  output  1  active-low decimal point.
REQ-012 Port an  output  8  active-low anodes, an[i] enables digit i.

Function
REQ-013 Tick counter SHALL count 0..TICK_DIV-1 and wrap; tick asserted in the cycle count == TICK_DIV-1.
REQ-014 3-bit scan index idx SHALL advance by 1 on each tick, wrapping 7 -> 0.
REQ-015 frame_start SHALL assert for exactly the cycle of the tick where idx is 7.
REQ-016 load SHALL write digits_in/dp_in into pending register and set pending; load while pending already set overwrites (last wins).
REQ-017 On a frame_start cycle with pending set and no load, pending data SHALL copy to display register and pending SHALL clear.
REQ-018 load coincident with frame_start SHALL write the new data directly to display register (bypassing stale pending data) and clear pending.
REQ-019 Display register SHALL change only on frame_start cycles (no tearing mid-frame).
REQ-020 seg, dp, an SHALL be registered, computed from current idx and display register, thus lagging idx by one clock.
REQ-021 an SHALL have exactly one bit low (bit idx) outside reset.
REQ-022 Decode, seg[6:0] g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-023 Nibble values 10..15 SHALL decode to 1111111 (blank); dp unaffected.
REQ-024 dp SHALL equal ~display_dp[idx].

Reset
REQ-025 While reset_n low at a clock edge: tick counter 0, idx 0, pending register and display register 0, pending 0, frame_start 0.
REQ-026 Reset outputs: an=11111111, seg=1111111, dp=1.
REQ-027 Reset mid-frame SHALL discard pending data; first cycle after release drives an=11111110 with digit 0 of zeroed display (seg=1000000).

Configuration
REQ-028 Macro SEG7_LZB_EN, when defined, SHALL enable leading-zero blanking: digits 7 downward that are 0 and above the highest nonzero digit decode to 1111111; digit 0 never blanked; dp unaffected.
REQ-029 Without SEG7_LZB_EN, every digit SHALL decode per REQ-022/REQ-023 with no blanking logic present.

Verification (CLK_FREQ=16, REFRESH_HZ=4, TICK_DIV=4 unless stated)
REQ-030 Reset release, no load -> an steps FE,FD,FB,...,7F every 4 clocks, seg=1000000 throughout, frame_start pulses every 32 clocks.
REQ-031 load digits_in=32'h87654321, dp_in=8'h01 mid-frame -> pending=1, display unchanged until frame_start, then digits 0..7 show 1..8, dp=0 only while an=FE.
REQ-032 Two loads (32'h11111111 then 32'h22222222) within one frame -> next frame shows all 2s, 1s never displayed.
REQ-033 load 32'h00000009 on frame_start cycle -> pending stays 0, displayed from the very next frame (digit 0 = 0010000).
REQ-034 digits_in=32'h0000A0C5 -> digits 1 and 3 blank (1111111); with SEG7_LZB_EN digits 4..7 also blank, without it digits 4..7 show 1000000.
REQ-035 Assert reset_n low for 1 cycle during digit 5 with pending=1 -> next cycle an=FF, seg=7F, pending=0; scan restarts at digit 0.
